// File: rtl/alu_pkg.sv
// Shared op-code constants, FSM states and decode helper for the ALU/MDU slice.
// Imported by the top-level control and the iterative multiply/divide engine.
package alu_pkg;

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_XOR   = 4'b0011;
  localparam logic [3:0] OP_SRA   = 4'b0100;
  localparam logic [3:0] OP_SLTU  = 4'b0101;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_MULT  = 4'b1000;
  localparam logic [3:0] OP_MULTU = 4'b1001;
  localparam logic [3:0] OP_DIV   = 4'b1010;
  localparam logic [3:0] OP_DIVU  = 4'b1011;
  localparam logic [3:0] OP_NOR   = 4'b1100;
  localparam logic [3:0] OP_RSVD  = 4'b1101;
  localparam logic [3:0] OP_SRL   = 4'b1110;
  localparam logic [3:0] OP_SLL   = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_e;

  // Multiply/divide ops occupy 10xx; bit 1 selects divide, bit 0 selects unsigned.
  function automatic logic is_muldiv(input logic [3:0] op);
    return op[3:2] == 2'b10;
  endfunction

endpackage

// File: rtl/alu_muldiv.sv
// Iterative multiply/divide engine: one shift-add or restoring-subtract step per cycle on magnitudes.
// Result is valid once WIDTH steps have run; sign correction is combinational on the output side.
module alu_muldiv
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             is_div,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             step,
  output logic             last,
  output logic [WIDTH-1:0] hi_res,
  output logic [WIDTH-1:0] lo_res
);

  logic [2*WIDTH-1:0] p_q, p_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   in1_q, in1_d;
  logic [SHW-1:0]     cnt_q, cnt_d;
  logic               is_div_q, is_div_d;
  logic               div_zero_q, div_zero_d;
  logic               neg_res_q, neg_res_d;
  logic               neg_rem_q, neg_rem_d;

  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     rem_sh, diff, sum;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quot, rem;

  always_comb begin
    p_d        = p_q;
    a_d        = a_q;
    in1_d      = in1_q;
    cnt_d      = cnt_q;
    is_div_d   = is_div_q;
    div_zero_d = div_zero_q;
    neg_res_d  = neg_res_q;
    neg_rem_d  = neg_rem_q;
    a_neg      = is_signed & in1[WIDTH-1];
    b_neg      = is_signed & in2[WIDTH-1];
    mag_a      = a_neg ? -in1 : in1;
    mag_b      = b_neg ? -in2 : in2;
    rem_sh     = {p_q[2*WIDTH-1:WIDTH], p_q[WIDTH-1]};
    diff       = rem_sh - {1'b0, a_q};
    sum        = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});

    if (load) begin
      in1_d      = in1;
      cnt_d      = '0;
      is_div_d   = is_div;
      div_zero_d = (in2 == '0);
      neg_res_d  = a_neg ^ b_neg;
      neg_rem_d  = a_neg;
      // Divide shifts the dividend through the low half; multiply walks the multiplier bits there.
      p_d        = {{WIDTH{1'b0}}, is_div ? mag_a : mag_b};
      a_d        = is_div ? mag_b : mag_a;
    end else if (step) begin
      cnt_d = cnt_q + SHW'(1);
      if (is_div_q) begin
        if (!diff[WIDTH]) p_d = {diff[WIDTH-1:0], p_q[WIDTH-2:0], 1'b1};
        else              p_d = {rem_sh[WIDTH-1:0], p_q[WIDTH-2:0], 1'b0};
      end else begin
        p_d = {sum, p_q[WIDTH-1:1]};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_q        <= '0;
      a_q        <= '0;
      in1_q      <= '0;
      cnt_q      <= '0;
      is_div_q   <= 1'b0;
      div_zero_q <= 1'b0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
    end else begin
      p_q        <= p_d;
      a_q        <= a_d;
      in1_q      <= in1_d;
      cnt_q      <= cnt_d;
      is_div_q   <= is_div_d;
      div_zero_q <= div_zero_d;
      neg_res_q  <= neg_res_d;
      neg_rem_q  <= neg_rem_d;
    end
  end

  always_comb begin
    last = (cnt_q == SHW'(WIDTH-1));
    prod = neg_res_q ? -p_q : p_q;
    quot = neg_res_q ? -p_q[WIDTH-1:0] : p_q[WIDTH-1:0];
    rem  = neg_rem_q ? -p_q[2*WIDTH-1:WIDTH] : p_q[2*WIDTH-1:WIDTH];
    if (!is_div_q) begin
      hi_res = prod[2*WIDTH-1:WIDTH];
      lo_res = prod[WIDTH-1:0];
    end else if (div_zero_q) begin
      hi_res = in1_q;
      lo_res = '1;
    end else begin
      hi_res = rem;
      lo_res = quot;
    end
  end

endmodule

// File: rtl/alu_mdu.sv
// ALU with iterative multiply/divide: single-cycle ops finish next cycle, mul/div take WIDTH+1 cycles.
// No backpressure queue: start while busy is dropped; flush aborts an in-flight mul/div.
module alu_mdu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             flush,
  output logic [WIDTH-1:0] result,
  output logic             zero_flag,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;

  logic             accept, md_op, md_last;
  logic [SHW-1:0]   sh;
  logic [WIDTH-1:0] alu_res, hi_res, lo_res;

  assign busy   = (state_q != IDLE);
  // Flush beats start on the same edge, even when idle.
  assign accept = start & ~busy & ~flush;
  assign md_op  = is_muldiv(op);
  assign sh     = in2[SHW-1:0];

  always_comb begin
    case (op)
      OP_AND:  alu_res = in1 & in2;
      OP_OR:   alu_res = in1 | in2;
      OP_ADD:  alu_res = in1 + in2;
      OP_XOR:  alu_res = in1 ^ in2;
      OP_SRA:  alu_res = $signed(in1) >>> sh;
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, in1 < in2};
      OP_SUB:  alu_res = in1 - in2;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(in1) < $signed(in2)};
      OP_NOR:  alu_res = ~(in1 | in2);
      OP_SRL:  alu_res = in1 >> sh;
      OP_SLL:  alu_res = in1 << sh;
      default: alu_res = '0;
    endcase
  end

  alu_muldiv #(.WIDTH(WIDTH), .SHW(SHW)) u_muldiv (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (accept & md_op),
    .is_div    (op[1]),
    .is_signed (~op[0]),
    .in1       (in1),
    .in2       (in2),
    .step      (state_q == RUN),
    .last      (md_last),
    .hi_res    (hi_res),
    .lo_res    (lo_res)
  );

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    zero_d   = zero_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: if (accept && md_op) state_d = RUN;
      RUN: begin
        if (flush)        state_d = IDLE;
        else if (md_last) state_d = FIN;
      end
      FIN: begin
        state_d = IDLE;
        if (!flush) begin
          hi_d = hi_res;
          lo_d = lo_res;
        end
      end
      default: state_d = IDLE;
    endcase
    if (accept && !md_op) begin
      result_d = alu_res;
      zero_d   = (alu_res == '0);
      done_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      result_q <= '0;
      zero_q   <= 1'b1;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  assign result    = result_q;
  assign zero_flag = zero_q;
  assign hi        = hi_q;
  assign lo        = lo_q;
  // A flush landing in FIN cancels that cycle's completion pulse.
  assign done      = done_q | ((state_q == FIN) & ~flush);

endmodule
